// File: rtl/ibex_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_sram_responder
//  Description : Single-port SRAM responder for an Ibex-style req/gnt/rvalid
//                bus. Inserts a programmable number of wait cycles before
//                each grant. Supports bit-masked writes and a fixed-latency
//                read pipeline with out-of-range error reporting. Keeps
//                saturating counters of granted reads and writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_sram_responder #(
  parameter int unsigned AddrWidth   = 18,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 1024,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] wmask_i,
  input  logic [3:0]           stall_cycles_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [1:0]           rerror_o,
  output logic [15:0]          num_reads_o,
  output logic [15:0]          num_writes_o
);

  // Storage index width; a one-word memory still needs a one-bit index.
  localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  // Depth extended by one bit so the range compare works even when
  // Depth == 2**AddrWidth.
  localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(Depth);

  // Grant FSM encoding
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  logic [0:0]          state;
  logic [3:0]          stall_cnt;
  logic                gnt;
  logic                in_range;
  logic [IdxWidth-1:0] idx;
  logic                write_en;
  logic                read_grant;
  logic                write_grant;

  // Storage; deliberately never reset.
  logic [DataWidth-1:0] mem [Depth];

  // Read pipeline. Empty slots always carry zero data and zero error, so
  // the response outputs are naturally zero when rvalid_o is low.
  logic [ReadLatency-1:0] pipe_valid;
  logic [DataWidth-1:0]   pipe_data [ReadLatency];
  logic [1:0]             pipe_err  [ReadLatency];

  logic [DataWidth-1:0]   rd_sample;
  logic [1:0]             rd_err;

  assign in_range    = ({1'b0, addr_i} < DepthExt);
  assign idx         = addr_i[IdxWidth-1:0];
  assign read_grant  = gnt & ~we_i;
  assign write_grant = gnt & we_i;
  assign write_en    = write_grant & in_range;

  // Grant decision: immediate in IDLE with no stall, otherwise only once
  // the stall counter has run out. Never grant while in reset.
  always_comb begin
    gnt = 1'b0;
    if (!rst_i && req_i) begin
      if (state == StIdle) begin
        gnt = (stall_cycles_i == 4'd0);
      end else begin
        gnt = (stall_cnt == 4'd0);
      end
    end
  end

  assign gnt_o = gnt;

  // Grant FSM and stall counter. The counter is loaded with N-1 on entry
  // to STALL so that the grant lands exactly N cycles after the request
  // first appeared (the IDLE cycle itself counts as the first wait cycle).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= StIdle;
      stall_cnt <= 4'd0;
    end else begin
      case (state)
        StIdle: begin
          if (req_i && (stall_cycles_i != 4'd0)) begin
            state     <= StStall;
            stall_cnt <= stall_cycles_i - 4'd1;
          end
        end
        StStall: begin
          if (!req_i) begin
            // Abandoned request: back to IDLE with nothing granted.
            state     <= StIdle;
            stall_cnt <= 4'd0;
          end else if (stall_cnt == 4'd0) begin
            // Grant is asserted this cycle.
            state <= StIdle;
          end else begin
            stall_cnt <= stall_cnt - 4'd1;
          end
        end
        default: begin
          state     <= StIdle;
          stall_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Bit-masked storage write for granted in-range writes.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem[idx] <= (mem[idx] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  // Value and error captured by a granted read; out-of-range reads return
  // zero data with the range error bit set.
  always_comb begin
    rd_sample = '0;
    rd_err    = 2'b00;
    if (read_grant) begin
      if (in_range) begin
        rd_sample = mem[idx];
      end else begin
        rd_err = 2'b01;
      end
    end
  end

  // Read pipeline stages; stage 0 samples storage at the grant edge and
  // later stages shift the response toward the outputs in grant order.
  generate
    for (genvar s = 0; s < ReadLatency; s++) begin : g_stage
      if (s == 0) begin : g_first
        // First stage captures the read sampled at the grant edge.
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            pipe_valid[0] <= 1'b0;
            pipe_data[0]  <= '0;
            pipe_err[0]   <= 2'b00;
          end else begin
            pipe_valid[0] <= read_grant;
            pipe_data[0]  <= rd_sample;
            pipe_err[0]   <= rd_err;
          end
        end
      end else begin : g_next
        // Later stages forward the previous stage unchanged.
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            pipe_valid[s] <= 1'b0;
            pipe_data[s]  <= '0;
            pipe_err[s]   <= 2'b00;
          end else begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_data[s]  <= pipe_data[s-1];
            pipe_err[s]   <= pipe_err[s-1];
          end
        end
      end
    end
  endgenerate

  assign rvalid_o = pipe_valid[ReadLatency-1];
  assign rdata_o  = pipe_valid[ReadLatency-1] ? pipe_data[ReadLatency-1] : '0;
  assign rerror_o = pipe_valid[ReadLatency-1] ? pipe_err[ReadLatency-1]  : 2'b00;

  // Saturating grant counters; dropped out-of-range writes still count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_reads_o  <= 16'd0;
      num_writes_o <= 16'd0;
    end else begin
      if (read_grant && (num_reads_o != 16'hFFFF)) begin
        num_reads_o <= num_reads_o + 16'd1;
      end
      if (write_grant && (num_writes_o != 16'hFFFF)) begin
        num_writes_o <= num_writes_o + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibex_sram_responder
//  Description : Directed self-checking bench. Two responders (read latency
//                1 and 3) share one stimulus stream so that both latencies
//                are checked against the same storage history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_sram_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [3:0]  stall;

  logic        gnt1, rvalid1, gnt3, rvalid3;
  logic [31:0] rdata1, rdata3;
  logic [1:0]  rerror1, rerror3;
  logic [15:0] nr1, nw1, nr3, nw3;

  int passed = 0;
  int total  = 0;

  ibex_sram_responder #(.AddrWidth(18), .DataWidth(32), .Depth(1024), .ReadLatency(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .stall_cycles_i(stall), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .rerror_o(rerror1), .num_reads_o(nr1), .num_writes_o(nw1)
  );

  ibex_sram_responder #(.AddrWidth(18), .DataWidth(32), .Depth(1024), .ReadLatency(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .stall_cycles_i(stall), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .rerror_o(rerror3), .num_reads_o(nr3), .num_writes_o(nw3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [17:0] a,
                       input logic [31:0] d, input logic [31:0] m, input logic [3:0] s);
    req = r; we = w; addr = a; wdata = d; wmask = m; stall = s;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 18'd0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    // Reset with a write request pending: no grant, no write
    rst = 1'b1;
    drive(1'b1, 1'b1, 18'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0);
    tick(); #2;
    check("gnt_in_reset_l1", gnt1, 0);
    check("gnt_in_reset_l3", gnt3, 0);
    tick();
    rst = 1'b0;
    idle(); #2;
    check("rst_rvalid", rvalid1, 0);
    check("rst_rdata", rdata1, 0);
    check("rst_rerror", rerror1, 0);
    check("rst_num_reads", nr1, 0);
    check("rst_num_writes", nw1, 0);
    check("rst_rvalid_l3", rvalid3, 0);

    // Full write then read of addr 5
    drive(1'b1, 1'b1, 18'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'd0); #2;
    check("wr5_gnt", gnt1, 1);
    tick();
    drive(1'b1, 1'b0, 18'd5, 32'd0, 32'd0, 4'd0); #2;
    check("rd5_gnt", gnt1, 1);
    check("wr_no_rvalid", rvalid1, 0);
    tick();
    idle(); #2;
    check("rd5_rvalid", rvalid1, 1);
    check("rd5_rdata", rdata1, 32'hDEAD_BEEF);
    check("rd5_rerror", rerror1, 0);
    check("rd5_l3_not_yet", rvalid3, 0);
    tick(); #2;
    check("rd5_rvalid_drop", rvalid1, 0);
    check("rd5_rdata_zero", rdata1, 0);
    tick(); #2;
    check("rd5_l3_rvalid", rvalid3, 1);
    check("rd5_l3_rdata", rdata3, 32'hDEAD_BEEF);
    tick();

    // Masked write: only bits 15:8 change
    drive(1'b1, 1'b1, 18'd5, 32'h0000_FFFF, 32'h0000_FF00, 4'd0); #2;
    check("mwr_gnt", gnt1, 1);
    tick();
    drive(1'b1, 1'b0, 18'd5, 32'd0, 32'd0, 4'd0);
    tick();
    idle(); #2;
    check("mrd_rvalid", rvalid1, 1);
    check("mrd_rdata", rdata1, 32'hDEAD_FFEF);
    check("mrd_num_writes", nw1, 2);
    check("mrd_num_reads", nr1, 2);
    tick();

    // Stall 3 with request held: grant on the 4th cycle; a stall change
    // mid-stall is ignored
    drive(1'b1, 1'b0, 18'd5, 32'd0, 32'd0, 4'd3); #2;
    check("stall_c0", gnt1, 0);
    tick();
    stall = 4'd0; #2;
    check("stall_c1", gnt1, 0);
    tick(); #2;
    check("stall_c2", gnt1, 0);
    tick(); #2;
    check("stall_c3", gnt1, 1);
    tick();
    idle(); #2;
    check("stall_rvalid", rvalid1, 1);
    check("stall_rdata", rdata1, 32'hDEAD_FFEF);
    check("stall_num_reads", nr1, 3);
    tick();

    // Stall 3 with request dropped after 2 cycles: no grant, no side effects
    drive(1'b1, 1'b0, 18'd5, 32'd0, 32'd0, 4'd3); #2;
    check("drop_c0", gnt1, 0);
    tick(); #2;
    check("drop_c1", gnt1, 0);
    tick();
    idle();
    tick(); #2;
    check("drop_num_reads", nr1, 3);
    check("drop_rvalid", rvalid1, 0);
    drive(1'b1, 1'b0, 18'd5, 32'd0, 32'd0, 4'd0); #2;
    check("drop_back_idle_gnt", gnt1, 1);
    tick();
    idle(); #2;
    check("drop_reread_rvalid", rvalid1, 1);
    check("drop_reread_num_reads", nr1, 4);

    // Back-to-back writes to addr 0..3, one grant per cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 18'(k), 32'h1000_0000 + 32'(k), 32'hFFFF_FFFF, 4'd0); #2;
      check("b2b_wr_gnt", gnt1, 1);
      tick();
    end

    // Back-to-back reads of addr 0..3; responses in order on both latencies
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 18'(k), 32'd0, 32'd0, 4'd0);
      else       idle();
      #2;
      if (k < 4) check("b2b_rd_gnt", gnt1, 1);
      check("b2b_l1_rvalid", rvalid1, (k >= 1 && k <= 4));
      check("b2b_l1_rdata", rdata1, (k >= 1 && k <= 4) ? 32'h1000_0000 + 32'(k - 1) : 32'd0);
      check("b2b_l3_rvalid", rvalid3, (k >= 3 && k <= 6));
      check("b2b_l3_rdata", rdata3, (k >= 3 && k <= 6) ? 32'h1000_0000 + 32'(k - 3) : 32'd0);
      tick();
    end

    // Out-of-range read and write
    drive(1'b1, 1'b0, 18'd2048, 32'd0, 32'd0, 4'd0); #2;
    check("oor_rd_gnt", gnt1, 1);
    tick();
    idle(); #2;
    check("oor_rd_rvalid", rvalid1, 1);
    check("oor_rd_rdata", rdata1, 0);
    check("oor_rd_rerror", rerror1, 2'b01);
    tick(); #2;
    check("oor_rerror_clear", rerror1, 0);
    drive(1'b1, 1'b1, 18'd2048, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0); #2;
    check("oor_wr_gnt", gnt1, 1);
    tick();
    idle(); #2;
    check("oor_wr_no_rvalid", rvalid1, 0);
    drive(1'b1, 1'b0, 18'd0, 32'd0, 32'd0, 4'd0);
    tick();
    idle(); #2;
    check("oor_wr_no_alias", rdata1, 32'h1000_0000);
    check("oor_num_writes", nw1, 7);
    check("oor_num_reads", nr1, 10);
    tick(); tick(); tick();

    // Reset with two reads in flight on the latency-3 responder
    drive(1'b1, 1'b0, 18'd1, 32'd0, 32'd0, 4'd0);
    tick();
    drive(1'b1, 1'b0, 18'd2, 32'd0, 32'd0, 4'd0);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 18'd1, 32'd0, 32'hFFFF_FFFF, 4'd0); #2;
    check("rst2_gnt", gnt1, 0);
    tick();
    rst = 1'b0;
    idle(); #2;
    check("rst2_num_reads", nr1, 0);
    check("rst2_num_writes", nw1, 0);
    check("rst2_l3_rvalid_a", rvalid3, 0);
    tick(); #2;
    check("rst2_l3_rvalid_b", rvalid3, 0);
    tick(); #2;
    check("rst2_l3_rvalid_c", rvalid3, 0);
    check("rst2_l3_num_reads", nr3, 0);
    drive(1'b1, 1'b0, 18'd1, 32'd0, 32'd0, 4'd0);
    tick();
    idle(); #2;
    check("rst2_reread_rvalid", rvalid1, 1);
    check("rst2_reread_rdata", rdata1, 32'h1000_0001);
    check("rst2_reread_num_reads", nr1, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
